// File: rtl/lcrc_pkg.sv
// Shared LCRC definitions for the receive checker and the transmit appender:
// polynomial, init value, status codes and the byte-wise CRC helpers.
package lcrc_pkg;

  localparam logic [31:0] LCRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] LCRC_INIT = 32'h0000_0000;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_CRC   = 2'b01;
  localparam logic [1:0] ST_RUNT  = 2'b10;
  localparam logic [1:0] ST_FRAME = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_ABORT
  } chk_state_e;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Bytes enter LSB first into an MSB-shifting LFSR.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ b[i];
      c  = {c[30:0], 1'b0} ^ (fb ? LCRC_POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [31:0] lcrc_field(input logic [31:0] crc);
    return {bitrev8(crc[31:24]), bitrev8(crc[23:16]), bitrev8(crc[15:8]), bitrev8(crc[7:0])};
  endfunction

endpackage

// File: rtl/lcrc_32_check_if.sv
// Byte-stream bus of the LCRC checker: input stream, payload output stream and status.
interface lcrc_32_check_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_bad;
  logic       st_valid;
  logic [1:0] st_code;

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_bad, st_valid, st_code
  );

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_bad, st_valid, st_code
  );
endinterface

// File: rtl/lcrc_32_delay4.sv
// Four-byte shift line holding the trailing LCRC candidate, with a fill count.
module lcrc_32_delay4 (
  input  logic        clk,
  input  logic        reset,
  input  logic        shift,
  input  logic        restart,
  input  logic        clear,
  input  logic [7:0]  din,
  output logic [7:0]  oldest,
  output logic [23:0] held,
  output logic [2:0]  count
);

  logic [31:0] line_q, line_d;
  logic [2:0]  count_q, count_d;

  // Newest byte sits in the low lane; clear only empties the count.
  always_comb begin
    line_d  = line_q;
    count_d = count_q;
    if (clear) begin
      count_d = 3'd0;
    end else if (shift) begin
      line_d = {line_q[23:0], din};
      if (restart) begin
        count_d = 3'd1;
      end else if (count_q != 3'd4) begin
        count_d = count_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q  <= 32'h0;
      count_q <= 3'd0;
    end else begin
      line_q  <= line_d;
      count_q <= count_d;
    end
  end

  assign oldest = line_q[31:24];
  assign held   = line_q[23:0];
  assign count  = count_q;

endmodule

// File: rtl/lcrc_32_check.sv
// Receive-side LCRC checker: strips the 4-byte LCRC, forwards payload, reports status.
// Optional saturating ok/bad counters are enabled by defining LCRC_CHK_CNT_EN.
module lcrc_32_check
  import lcrc_pkg::*;
#(
  parameter int MIN_PAYLOAD = 1
) (
  input  logic clk,
  input  logic reset,
`ifdef LCRC_CHK_CNT_EN
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_bad,
`endif
  lcrc_32_check_if.slave bus
);

  chk_state_e  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic        out_bad_q, out_bad_d;
  logic        st_valid_q, st_valid_d;
  logic [1:0]  st_code_q, st_code_d;

  logic        line_shift, line_restart, line_clear;
  logic [7:0]  line_oldest;
  logic [23:0] line_held;
  logic [2:0]  line_count;
  logic        slot_free, sop_stall, in_ready, accept, crc_ok, runt;
  logic [31:0] next_crc;

  lcrc_32_delay4 u_line (
    .clk     (clk),
    .reset   (reset),
    .shift   (line_shift),
    .restart (line_restart),
    .clear   (line_clear),
    .din     (bus.in_data),
    .oldest  (line_oldest),
    .held    (line_held),
    .count   (line_count)
  );

  // A new sop in RUN is refused so it can be replayed into IDLE after the abort beat.
  assign slot_free = !out_valid_q || bus.out_ready;
  assign sop_stall = (state_q == S_RUN) && bus.in_valid && bus.in_sop;
  assign in_ready  = !reset && (state_q != S_ABORT) && slot_free && !sop_stall;
  assign accept    = bus.in_valid && in_ready;
  assign next_crc  = crc32_byte(crc_q, line_oldest);
  assign crc_ok    = (lcrc_field(next_crc) == {line_held, bus.in_data});
  assign runt      = (int'(pay_cnt_q) + 1) < MIN_PAYLOAD;

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    pay_cnt_d    = pay_cnt_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_bad_d    = out_bad_q;
    st_valid_d   = 1'b0;
    st_code_d    = st_code_q;
    line_shift   = 1'b0;
    line_restart = 1'b0;
    line_clear   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.in_sop) begin
          crc_d     = LCRC_INIT;
          pay_cnt_d = 16'd0;
          if (bus.in_eop) begin
            st_valid_d = 1'b1;
            st_code_d  = ST_RUNT;
            line_clear = 1'b1;
          end else begin
            line_shift   = 1'b1;
            line_restart = 1'b1;
            state_d      = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (accept) begin
          if (bus.in_sop) begin
            st_valid_d   = 1'b1;
            st_code_d    = ST_FRAME;
            line_shift   = 1'b1;
            line_restart = 1'b1;
            crc_d        = LCRC_INIT;
            pay_cnt_d    = 16'd0;
          end else if (bus.in_eop) begin
            st_valid_d = 1'b1;
            st_code_d  = ST_RUNT;
            line_clear = 1'b1;
            state_d    = S_IDLE;
          end else begin
            line_shift = 1'b1;
            if (line_count == 3'd3) state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (sop_stall && slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          out_bad_d   = 1'b1;
          st_valid_d  = 1'b1;
          st_code_d   = ST_FRAME;
          line_clear  = 1'b1;
          state_d     = S_ABORT;
        end else if (accept) begin
          line_shift  = 1'b1;
          crc_d       = next_crc;
          if (pay_cnt_q != 16'hFFFF) pay_cnt_d = pay_cnt_q + 16'd1;
          out_valid_d = 1'b1;
          out_data_d  = line_oldest;
          out_sop_d   = (pay_cnt_q == 16'd0);
          out_eop_d   = bus.in_eop;
          out_bad_d   = 1'b0;
          if (bus.in_eop) begin
            st_valid_d = 1'b1;
            line_clear = 1'b1;
            state_d    = S_IDLE;
            if (runt) begin
              out_bad_d = 1'b1;
              st_code_d = ST_RUNT;
            end else if (!crc_ok) begin
              out_bad_d = 1'b1;
              st_code_d = ST_CRC;
            end else begin
              st_code_d = ST_OK;
            end
          end
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      crc_q       <= LCRC_INIT;
      pay_cnt_q   <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_bad_q   <= 1'b0;
      st_valid_q  <= 1'b0;
      st_code_q   <= ST_OK;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      pay_cnt_q   <= pay_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_bad_q   <= out_bad_d;
      st_valid_q  <= st_valid_d;
      st_code_q   <= st_code_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_bad   = out_bad_q;
  assign bus.st_valid  = st_valid_q;
  assign bus.st_code   = st_code_q;

`ifdef LCRC_CHK_CNT_EN
  logic [15:0] cnt_ok_q, cnt_ok_d, cnt_bad_q, cnt_bad_d;

  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_bad_d = cnt_bad_q;
    if (st_valid_q) begin
      if (st_code_q == ST_OK) begin
        if (cnt_ok_q != 16'hFFFF) cnt_ok_d = cnt_ok_q + 16'd1;
      end else begin
        if (cnt_bad_q != 16'hFFFF) cnt_bad_d = cnt_bad_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_ok_q  <= 16'd0;
      cnt_bad_q <= 16'd0;
    end else begin
      cnt_ok_q  <= cnt_ok_d;
      cnt_bad_q <= cnt_bad_d;
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_bad = cnt_bad_q;
`else
  // Counter-free build: status is reported only through st_valid/st_code.
`endif

endmodule
